mux8_scan: RTL and testbench

Scan sequencer that drives the 3-bit select of the 8-to-1 mux stage and consumes its 1-bit output. It steps the select through channels 0..7, waits a programmable settle time per channel, samples the mux output and assembles an 8-bit frame. The frame goes to a downstream consumer over a valid/ready handshake. The block sits directly upstream (select) and downstream (output) of the mux, and turns 8 switch-type inputs into one parallel word.

---
 rtl/mux8_scan_pkg.sv | 21 ++
 rtl/mux8_scan.sv | 93 +++++++++
 tb/tb_mux8_scan.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mux8_scan_pkg.sv
// Shared constants and state encoding for the 8-channel mux scan sequencer.
package mux8_scan_pkg;

  localparam int N_CH       = 8;
  localparam int SEL_W      = 3;
  localparam int CNT_W      = 4;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  function automatic bit settle_legal(input int settle);
    return (settle >= SETTLE_MIN) && (settle <= SETTLE_MAX);
  endfunction

endpackage

// File: rtl/mux8_scan.sv
// Steps the 8:1 mux select, samples its output after a settle delay per channel,
// and hands the assembled 8-bit frame downstream over valid/ready.
module mux8_scan
  import mux8_scan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cont,
  input  logic             mux_o,
  output logic [SEL_W-1:0] s,
  output logic [N_CH-1:0]  data,
  output logic             valid,
  input  logic             ready,
  output logic             busy
);

  if (!settle_legal(SETTLE)) begin : g_bad_settle
    $error("mux8_scan: SETTLE must be in 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N_CH - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [N_CH-1:0]   shift;
  logic [N_CH-1:0]   frame;

  // NOTE: combinational blocks assign a full default first so no latch is inferred.
  always_comb begin
    frame    = shift;
    frame[s] = mux_o;
  end

  // NOTE: all state below is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_IDLE;
      s     <= '0;
      cnt   <= '0;
      shift <= '0;
      data  <= '0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SETTLE;
            s     <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          shift <= frame;
          // Only a fully assembled frame is published; partial scans stay internal.
          if (s == SEL_LAST) begin
            data  <= frame;
            valid <= 1'b1;
            state <= ST_HOLD;
          end else begin
            s     <= s + 1'b1;
            cnt   <= '0;
            state <= ST_SETTLE;
          end
        end
        ST_HOLD: begin
          if (valid && ready) begin
            valid <= 1'b0;
            s     <= '0;
            cnt   <= '0;
            if (cont) begin
              state <= ST_SETTLE;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux8_scan.sv
// Directed self-checking bench for mux8_scan: SETTLE=2 and SETTLE=1 instances,
// each driving a behavioural 8:1 mux built from inputs a..h (bit 0 = a).
module tb_mux8_scan;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, cont, ready;
  logic [7:0] ins;
  logic       mux_o;
  logic [2:0] s;
  logic [7:0] data;
  logic       valid, busy;

  logic       start1, cont1, ready1;
  logic [7:0] ins1;
  logic       mux_o1;
  logic [2:0] s1;
  logic [7:0] data1;
  logic       valid1, busy1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mux_o  = ins[s];
  assign mux_o1 = ins1[s1];

  mux8_scan #(.SETTLE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .mux_o(mux_o),
    .s(s), .data(data), .valid(valid), .ready(ready), .busy(busy)
  );

  mux8_scan #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cont(cont1), .mux_o(mux_o1),
    .s(s1), .data(data1), .valid(valid1), .ready(ready1), .busy(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Steps until valid rises or the budget runs out; returns cycles taken.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    while (!valid && n < max) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    rst = 1'b0; start = 1'b0; cont = 1'b0; ready = 1'b1; ins = 8'h00;
    start1 = 1'b0; cont1 = 1'b0; ready1 = 1'b1; ins1 = 8'h00;
    step(); step();
    check("rst_s", 32'(s), 32'd0);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    step();

    // Basic frame, SETTLE=2, ready high
    ins = 8'hA6;
    start = 1'b1; step(); start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 3; j++) begin
        check($sformatf("sel_ch%0d_c%0d", i, j), 32'(s), 32'(i));
        check("valid_low_scan", 32'(valid), 32'd0);
        step();
      end
    end
    check("f1_valid", 32'(valid), 32'd1);
    check("f1_data", 32'(data), 32'hA6);
    check("f1_s", 32'(s), 32'd7);
    step();
    check("f1_valid_pulse", 32'(valid), 32'd0);
    check("f1_busy_drop", 32'(busy), 32'd0);
    check("f1_s_back", 32'(s), 32'd0);

    // Backpressure with ignored start pulses
    ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    wait_valid(100, n);
    check("bp_latency", 32'(n), 32'd24);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_hold", 32'(valid), 32'd1);
      check("bp_data_hold", 32'(data), 32'hA6);
      check("bp_s_hold", 32'(s), 32'd7);
      check("bp_busy", 32'(busy), 32'd1);
      start = (i == 3 || i == 6);
      ins   = 8'(i);
      step();
      start = 1'b0;
    end
    ready = 1'b1;
    step();
    check("bp_release_valid", 32'(valid), 32'd0);
    check("bp_release_busy", 32'(busy), 32'd0);
    step();
    check("bp_stays_idle", 32'(busy), 32'd0);

    // Continuous mode, two frames
    ins = 8'h5A; cont = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    wait_valid(100, n);
    check("c1_latency", 32'(n), 32'd24);
    check("c1_data", 32'(data), 32'h5A);
    ins = 8'hFF;
    step();
    check("c1_handshake_valid", 32'(valid), 32'd0);
    check("c1_rescan_busy", 32'(busy), 32'd1);
    check("c1_rescan_s", 32'(s), 32'd0);
    cont = 1'b0;
    wait_valid(100, n);
    check("c2_period", 32'(n + 1), 32'd25);
    check("c2_data", 32'(data), 32'hFF);
    step();
    check("c2_idle_busy", 32'(busy), 32'd0);
    check("c2_idle_valid", 32'(valid), 32'd0);

    // Reset in the middle of a scan
    start = 1'b1; step(); start = 1'b0;
    n = 0;
    while (s != 3'd4 && n < 100) begin
      step();
      n++;
    end
    check("mid_reach_s4", 32'(s), 32'd4);
    rst = 1'b0;
    step();
    check("mid_rst_s", 32'(s), 32'd0);
    check("mid_rst_data", 32'(data), 32'h00);
    check("mid_rst_valid", 32'(valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    ins = 8'h3C;
    step();
    start = 1'b1; step(); start = 1'b0;
    wait_valid(100, n);
    check("post_rst_latency", 32'(n), 32'd24);
    check("post_rst_data", 32'(data), 32'h3C);
    step();

    // Glitch immunity on channel 3: noisy during settle, 1 on sample cycle
    ins = 8'h00;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("gl_s3", 32'(s), 32'd3);
    for (int i = 0; i < 2; i++) begin
      ins[3] = 1'b1; #3; ins[3] = 1'b0; #2; ins[3] = 1'b1; #2; ins[3] = 1'b0;
      step();
    end
    ins[3] = 1'b1;
    step();
    ins[3] = 1'b0;
    wait_valid(100, n);
    check("gl_latency", 32'(n), 32'd12);
    check("gl_data", 32'(data), 32'h08);
    step();

    // SETTLE=1 instance
    ins1 = 8'h81;
    start1 = 1'b1; step(); start1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 2; j++) begin
        check($sformatf("s1_sel_ch%0d_c%0d", i, j), 32'(s1), 32'(i));
        check("s1_valid_low", 32'(valid1), 32'd0);
        step();
      end
    end
    check("s1_valid", 32'(valid1), 32'd1);
    check("s1_data", 32'(data1), 32'h81);
    step();
    check("s1_valid_pulse", 32'(valid1), 32'd0);
    check("s1_busy_drop", 32'(busy1), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
